// File: rtl/mm_pkg.sv
// Shared types and helpers for the matmul result reader.
// Holds the FSM encoding, the result element type and index sizing.
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM
  } state_t;

  localparam int BW_DEF = 8;

  typedef logic [2*BW_DEF-1:0] res_t;

  function automatic int idx_w(int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/matmul_result_reader_if.sv
// Valid/ready stream carrying one result element per transfer.
// The reader drives the master side; the consumer is the slave.
interface matmul_result_reader_if #(
  parameter int DW = 16,
  parameter int IW = 4
);

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/matmul_result_reader_timer.sv
// Pipeline latency timer: loads LATENCY-1, counts down to zero.
// The zero flag marks the cycle before results are captured.
module latency_timer #(
  parameter int LATENCY = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_zero
);

  localparam int CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_V =
    CW'(LATENCY - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_V;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/matmul_result_reader.sv
// Snapshots the multiplier result array after a fixed latency
// and streams the elements out in row-major order.
module matmul_result_reader
  import mm_pkg::*;
#(
  parameter int N        = 3,
  parameter int BitWidth = 8,
  parameter int LATENCY  = 2 * N + 1,
  parameter int IDX_W    = idx_w(N)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [N*N*2*BitWidth-1:0]   res_in,
  output logic                        busy,
  matmul_result_reader_if.master      o_s
);

  localparam int RW = 2 * BitWidth;
  localparam int NE = N * N;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NE - 1);

  state_t            r_state;
  logic [RW-1:0]     r_buf [NE];
  logic [IDX_W-1:0]  r_idx;
  logic              r_valid;
  logic [RW-1:0]     r_data;
  logic              r_last;

  logic              w_xfer;
  logic              w_end;
  logic              w_load;
  logic              w_zero;
  logic [IDX_W-1:0]  w_idx_nxt;

  assign w_xfer    = r_valid & o_s.out_ready;
  assign w_end     = w_xfer & (r_idx == LAST);
  assign w_load    = start &
                     ((r_state == IDLE) | w_end);
  assign w_idx_nxt = r_idx + IDX_W'(1);

  latency_timer #(
    .LATENCY (LATENCY)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_load (w_load),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      for (int k = 0; k < NE; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      unique case (1'b1)
        (r_state == IDLE): begin
          if (start) r_state <= WAIT;
        end
        (r_state == WAIT): begin
          if (w_zero) begin
            for (int k = 0; k < NE; k++) begin
              r_buf[k] <= res_in[k*RW +: RW];
            end
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_data  <= res_in[RW-1:0];
            r_last  <= (NE == 1);
            r_state <= STREAM;
          end
        end
        (r_state == STREAM): begin
          if (w_end) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_state <= start ? WAIT : IDLE;
          end else if (w_xfer) begin
            r_idx   <= w_idx_nxt;
            r_data  <= r_buf[w_idx_nxt];
            r_last  <= (w_idx_nxt == LAST);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign o_s.out_valid = r_valid;
  assign o_s.out_data  = r_data;
  assign o_s.out_idx   = r_idx;
  assign o_s.out_last  = r_last;

endmodule
